adder16_rr_sched: RTL and testbench
===================================

Name: adder16_rr_sched

Overview:
- Shares one registered 16-bit add stage among NREQ requesters.
- Round-robin arbitration; the grant is locked for a whole multi-word packet (beats up to and including req_last).
- Carry is chained between beats of a packet, so any requester can perform 16*k-bit additions one word per beat, least-significant word first.
- Results and status flags (sign, zero, carry, parity, overflow) go out on a single valid/ready response port tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester beat valid
- req_last  in  NREQ  per-requester: current beat is the final (most-significant) word
- req_x  in  NREQ*16  operand A words; requester i uses bits [16i+15:16i]
- req_y  in  NREQ*16  operand B words; same packing as req_x
- req_ready  out  NREQ  per-requester beat accept
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  requester that produced the result
- rsp_z  out  16  sum word
- rsp_last  out  1  copy of req_last for this beat
- rsp_sign  out  1  rsp_z[15]
- rsp_zero  out  1  1 when this word and all earlier words of the packet are zero
- rsp_carry  out  1  carry out of this word
- rsp_parity  out  1  even parity of rsp_z: XNOR-reduce, 1 when the count of ones is even
- rsp_overflow  out  1  signed overflow of this word: (x15 & y15 & ~z15) | (~x15 & ~y15 & z15)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE, rr pointer=0, carry reg=0, zero-accumulator=1.
  - All rsp_* outputs=0; req_ready=0.
- State IDLE:
  - req_ready=0.
  - If any req_valid: select the first requester with valid set, searching from the pointer upward with wrap-around. Register it as grant and go to BURST.
  - Clear carry reg to 0 and zero-accumulator to 1.
  - With no valid, stay in IDLE.
- State BURST:
  - req_ready[grant] = !rsp_valid | rsp_ready. All other req_ready bits are 0.
  - req_ready is combinational from state and rsp handshake only, never from req_valid.
- Beat accept (req_valid[grant] & req_ready[grant]), next edge:
  - {carry,z} = x + y + carry_reg, 17-bit.
  - Load the response register with z, flags, id=grant, last=req_last[grant], and set rsp_valid=1.
  - carry_reg <= carry.
  - zero_acc <= zero_acc & (z==0); rsp_zero is the updated value.
- Last beat accepted: pointer <= grant+1 (wraps modulo NREQ), state <= IDLE. Each packet therefore costs 1 arbitration bubble.
- Granted requester drops req_valid mid-packet: grant is held and no other requester is served. Carry and zero state are retained.
- Response handshake:
  - rsp_valid & rsp_ready with no new beat: rsp_valid <= 0 next edge.
  - Same-cycle drain and new accept is allowed; gives a full rate of 1 beat/cycle.
  - While rsp_valid & !rsp_ready, all rsp_* outputs hold stable.
- Latency: accepted beat to rsp_valid = 1 cycle.
- Requester contract: req_valid, once raised, is not required to hold; req_x, req_y and req_last are sampled only on accept.
- Flag semantics: sign, overflow and carry are meaningful for the whole operand only on the last beat.
- A 1-beat packet is a plain 16-bit add with cin=0.

Test Plan:
- Req0 single beat: x=0x7FFF, y=0x0001, last=1 -> after 1 cycle: rsp_z=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0, id=0, last=1.
- Req2 32-bit packet: beat0 x=0xFFFF, y=0x0001, last=0 -> z=0x0000, carry=1, zero=1. Beat1 x=0, y=0, last=1 -> z=0x0001, carry=0, zero=0, id=2 on both beats.
- After reset, all 4 requesters raise 1-beat requests together -> rsp_id order 0,1,2,3, each separated by 1 bubble cycle. Then req1 and req3 request together -> order 1, 3.
- Backpressure: hold rsp_ready=0 for 5 cycles during a 3-beat packet -> rsp_* stable, req_ready[grant]=0, no beat lost or duplicated. Final rsp_z values match the 48-bit reference sum.
- Zero/overflow chain, 2 beats: 0x0000+0x0000, then 0x8000+0x8000 -> last rsp_z=0x0000, carry=1, overflow=1, zero=1, parity=1.
- Assert rst_n low during beat 2 of a 3-beat packet -> all outputs immediately 0, state IDLE. A new 1-beat packet 0xFFFF+0x0001 gives z=0x0000, carry=1 (carry_reg cleared, no stale cin).

Source files
------------

// File: rtl/adder16_rr_sched_if.sv
// Request/response bundle for the shared 16-bit add stage.
// slave = scheduler side, master = requesters plus response consumer.
interface adder16_rr_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*16-1:0] req_x;
  logic [NREQ*16-1:0] req_y;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_z;
  logic               rsp_last;
  logic               rsp_sign;
  logic               rsp_zero;
  logic               rsp_carry;
  logic               rsp_parity;
  logic               rsp_overflow;

  modport slave (
    input  req_valid, req_last, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_last,
           rsp_sign, rsp_zero, rsp_carry, rsp_parity, rsp_overflow
  );

  modport master (
    output req_valid, req_last, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_last,
           rsp_sign, rsp_zero, rsp_carry, rsp_parity, rsp_overflow
  );
endinterface

// File: rtl/adder16_rr_sched.sv
// Round-robin shared 16-bit adder: grant held per packet, carry chained
// across beats, single registered response port tagged with requester id.
module adder16_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  adder16_rr_sched_if.slave   bus
);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           carry_q, carry_d;
  logic           zacc_q, zacc_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    rsp_z_q, rsp_z_d;
  logic           rsp_last_q, rsp_last_d;
  logic           rsp_sign_q, rsp_sign_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_parity_q, rsp_parity_d;
  logic           rsp_ovf_q, rsp_ovf_d;

  logic           any_valid;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] idx;

  logic           ready_grant;
  logic [NREQ-1:0] req_ready_c;
  logic [15:0]    x_sel, y_sel;
  logic           valid_sel, last_sel;
  logic           accept;
  logic [16:0]    sum;
  logic           zacc_new;

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr_q) + i) % NREQ);
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        pick      = idx;
      end
    end
  end

  assign ready_grant = (state_q == BURST) && (!rsp_valid_q || bus.rsp_ready);

  always_comb begin
    x_sel       = '0;
    y_sel       = '0;
    valid_sel   = 1'b0;
    last_sel    = 1'b0;
    req_ready_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_q) begin
        x_sel          = bus.req_x[i*16 +: 16];
        y_sel          = bus.req_y[i*16 +: 16];
        valid_sel      = bus.req_valid[i];
        last_sel       = bus.req_last[i];
        req_ready_c[i] = ready_grant;
      end
    end
  end

  assign accept   = ready_grant && valid_sel;
  assign sum      = {1'b0, x_sel} + {1'b0, y_sel} + {16'b0, carry_q};
  assign zacc_new = zacc_q && (sum[15:0] == 16'h0000);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    carry_d      = carry_q;
    zacc_d       = zacc_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_z_d      = rsp_z_q;
    rsp_last_d   = rsp_last_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_parity_d = rsp_parity_q;
    rsp_ovf_d    = rsp_ovf_q;

    // Drain first; a same-cycle accept below re-asserts valid.
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        carry_d = 1'b0;
        zacc_d  = 1'b1;
        if (any_valid) begin
          grant_d = pick;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = grant_q;
          rsp_z_d      = sum[15:0];
          rsp_last_d   = last_sel;
          rsp_sign_d   = sum[15];
          rsp_zero_d   = zacc_new;
          rsp_carry_d  = sum[16];
          rsp_parity_d = ~^sum[15:0];
          rsp_ovf_d    = (x_sel[15] & y_sel[15] & ~sum[15]) |
                         (~x_sel[15] & ~y_sel[15] & sum[15]);
          carry_d      = sum[16];
          zacc_d       = zacc_new;
          if (last_sel) begin
            ptr_d   = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      carry_q      <= 1'b0;
      zacc_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_z_q      <= '0;
      rsp_last_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_parity_q <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      carry_q      <= carry_d;
      zacc_q       <= zacc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_z_q      <= rsp_z_d;
      rsp_last_q   <= rsp_last_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_parity_q <= rsp_parity_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_z        = rsp_z_q;
  assign bus.rsp_last     = rsp_last_q;
  assign bus.rsp_sign     = rsp_sign_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_parity   = rsp_parity_q;
  assign bus.rsp_overflow = rsp_ovf_q;

endmodule

// File: tb/tb_adder16_rr_sched.sv
// Bench for adder16_rr_sched: directed scenarios plus a randomized run
// checked against a wide-integer packet-sum model with round-robin ordering.
module tb_adder16_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int NP   = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder16_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  adder16_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    z;
    logic           last;
    logic           sign;
    logic           zero;
    logic           carry;
    logic           parity;
    logic           ovf;
  } rsp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  rsp_t exp_q[$];
  int   ord_q[$];
  int   tim_q[$];
  int   rid_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic rsp_t cur_rsp();
    rsp_t r;
    r = {bus.rsp_id, bus.rsp_z, bus.rsp_last, bus.rsp_sign, bus.rsp_zero,
         bus.rsp_carry, bus.rsp_parity, bus.rsp_overflow};
    return r;
  endfunction

  // Expected response words of a k-word packet from full-width sums.
  function automatic void ref_packet(input int id, input int k,
                                     input logic [47:0] X, input logic [47:0] Y);
    longint unsigned m, part;
    logic [15:0] xw, yw;
    rsp_t r;
    for (int w = 0; w < k; w++) begin
      m        = (64'd1 << (16 * (w + 1))) - 64'd1;
      part     = (64'(X) & m) + (64'(Y) & m);
      r.id     = IDW'(id);
      r.z      = 16'(part >> (16 * w));
      r.last   = (w == k - 1);
      r.sign   = r.z[15];
      r.zero   = ((part & m) == 64'd0);
      r.carry  = 1'(part >> (16 * (w + 1)));
      r.parity = ~^r.z;
      xw       = 16'(X >> (16 * w));
      yw       = 16'(Y >> (16 * w));
      r.ovf    = (xw[15] & yw[15] & ~r.z[15]) | (~xw[15] & ~yw[15] & r.z[15]);
      exp_q.push_back(r);
    end
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input int r, input logic [15:0] x, input logic [15:0] y,
                           input logic last);
    int n;
    @(negedge clk);
    bus.req_valid[r]       = 1'b1;
    bus.req_x[r*16 +: 16]  = x;
    bus.req_y[r*16 +: 16]  = y;
    bus.req_last[r]        = last;
    #1;
    n = 0;
    while (!bus.req_ready[r] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready[r]) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout req=%0d ready=%b required 1", r, bus.req_ready[r]);
    end
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
  endtask

  // Raise 1-beat requests on every requester in mask; log accept order/cycle/id.
  task automatic run_single_beats(input logic [NREQ-1:0] mask);
    int n, acc;
    ord_q.delete(); tim_q.delete(); rid_q.delete();
    for (int r = 0; r < NREQ; r++) begin
      if (mask[r]) begin
        bus.req_valid[r]      = 1'b1;
        bus.req_last[r]       = 1'b1;
        bus.req_x[r*16 +: 16] = 16'(r);
        bus.req_y[r*16 +: 16] = 16'h0100;
      end
    end
    n = 0;
    while (bus.req_valid != '0 && n < 40) begin
      @(negedge clk);
      #1;
      acc = -1;
      for (int r = 0; r < NREQ; r++)
        if (bus.req_valid[r] && bus.req_ready[r]) acc = r;
      if (acc >= 0) begin
        ord_q.push_back(acc);
        tim_q.push_back(cyc);
        @(posedge clk);
        #1;
        bus.req_valid[acc] = 1'b0;
        rid_q.push_back(int'(bus.rsp_id));
      end
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_x = '0; bus.req_y = '0;
    bus.rsp_ready = 1'b0;
    #3;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset_valid_ready got valid=%b ready=%b required 0/0", bus.rsp_valid, bus.req_ready);
    end
    checks++;
    if (cur_rsp() !== '0) begin
      errors++;
      $display("FAIL reset_rsp got %h required 0", cur_rsp());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got valid=%b ready=%b required 0/0", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_single_beat();
    rsp_t e;
    bus.rsp_ready = 1'b1;
    send_beat(0, 16'h7FFF, 16'h0001, 1'b1);
    e = '{id: 2'd0, z: 16'h8000, last: 1, sign: 1, zero: 0, carry: 0, parity: 0, ovf: 1};
    checks++;
    if (bus.rsp_valid !== 1'b1 || cur_rsp() !== e) begin
      errors++;
      $display("FAIL single_beat got v=%b %h required v=1 %h", bus.rsp_valid, cur_rsp(), e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got valid=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_chain32();
    rsp_t e;
    bus.rsp_ready = 1'b1;
    send_beat(2, 16'hFFFF, 16'h0001, 1'b0);
    e = '{id: 2'd2, z: 16'h0000, last: 0, sign: 0, zero: 1, carry: 1, parity: 1, ovf: 0};
    checks++;
    if (cur_rsp() !== e) begin
      errors++;
      $display("FAIL chain32_beat0 got %h required %h", cur_rsp(), e);
    end
    send_beat(2, 16'h0000, 16'h0000, 1'b1);
    e = '{id: 2'd2, z: 16'h0001, last: 1, sign: 0, zero: 0, carry: 0, parity: 0, ovf: 0};
    checks++;
    if (cur_rsp() !== e) begin
      errors++;
      $display("FAIL chain32_beat1 got %h required %h", cur_rsp(), e);
    end
  endtask

  task automatic test_zero_overflow();
    rsp_t e;
    bus.rsp_ready = 1'b1;
    send_beat(3, 16'h0000, 16'h0000, 1'b0);
    e = '{id: 2'd3, z: 16'h0000, last: 0, sign: 0, zero: 1, carry: 0, parity: 1, ovf: 0};
    checks++;
    if (cur_rsp() !== e) begin
      errors++;
      $display("FAIL zero_ovf_beat0 got %h required %h", cur_rsp(), e);
    end
    send_beat(3, 16'h8000, 16'h8000, 1'b1);
    e = '{id: 2'd3, z: 16'h0000, last: 1, sign: 0, zero: 1, carry: 1, parity: 1, ovf: 1};
    checks++;
    if (cur_rsp() !== e) begin
      errors++;
      $display("FAIL zero_ovf_beat1 got %h required %h", cur_rsp(), e);
    end
  endtask

  task automatic test_rr_order();
    do_reset();
    bus.rsp_ready = 1'b1;
    run_single_beats(4'b1111);
    checks++;
    if (ord_q.size() != 4) begin
      errors++;
      $display("FAIL rr_all_count got %0d required 4", ord_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ord_q[i] != i || rid_q[i] != i) begin
          errors++;
          $display("FAIL rr_all_order slot=%0d got grant=%0d id=%0d required %0d", i, ord_q[i], rid_q[i], i);
        end
        if (i > 0) begin
          checks++;
          if (tim_q[i] - tim_q[i-1] != 2) begin
            errors++;
            $display("FAIL rr_bubble slot=%0d got spacing=%0d required 2", i, tim_q[i] - tim_q[i-1]);
          end
        end
      end
    end
    run_single_beats(4'b1010);
    checks++;
    if (ord_q.size() != 2 || ord_q[0] != 1 || ord_q[1] != 3) begin
      errors++;
      $display("FAIL rr_pair_order got size=%0d first=%0d required 1,3", ord_q.size(),
               ord_q.size() > 0 ? ord_q[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] X, Y;
    rsp_t e0, e1, e2;
    X = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    Y = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    X[15:0] = 16'hFFFF;
    exp_q.delete();
    ref_packet(1, 3, X, Y);
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    bus.rsp_ready = 1'b1;
    send_beat(1, X[15:0], Y[15:0], 1'b0);
    checks++;
    if (cur_rsp() !== e0) begin
      errors++;
      $display("FAIL bp_beat0 got %h required %h", cur_rsp(), e0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.req_x[16 +: 16] = X[31:16];
    bus.req_y[16 +: 16] = Y[31:16];
    bus.req_last[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.req_ready[1] !== 1'b0 || bus.rsp_valid !== 1'b1 || cur_rsp() !== e0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b %h required rdy=0 v=1 %h",
                 k, bus.req_ready[1], bus.rsp_valid, cur_rsp(), e0);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got %b required 1", bus.req_ready[1]);
    end
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || cur_rsp() !== e1) begin
      errors++;
      $display("FAIL bp_beat1 got v=%b %h required v=1 %h", bus.rsp_valid, cur_rsp(), e1);
    end
    send_beat(1, X[47:32], Y[47:32], 1'b1);
    checks++;
    if (cur_rsp() !== e2) begin
      errors++;
      $display("FAIL bp_beat2 got %h required %h", cur_rsp(), e2);
    end
  endtask

  task automatic test_reset_midpacket();
    rsp_t e;
    bus.rsp_ready = 1'b1;
    send_beat(2, 16'hFFFF, 16'hFFFF, 1'b0);
    send_beat(2, 16'hFFFF, 16'h0000, 1'b0);
    @(negedge clk);
    bus.req_valid[2] = 1'b1;
    bus.req_x[32 +: 16] = 16'h1234;
    bus.req_y[32 +: 16] = 16'h4321;
    bus.req_last[2] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0 || cur_rsp() !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%b rdy=%b %h required all 0", bus.rsp_valid, bus.req_ready, cur_rsp());
    end
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(0, 16'hFFFF, 16'h0001, 1'b1);
    e = '{id: 2'd0, z: 16'h0000, last: 1, sign: 0, zero: 1, carry: 1, parity: 1, ovf: 0};
    checks++;
    if (cur_rsp() !== e) begin
      errors++;
      $display("FAIL post_reset_add got %h required %h", cur_rsp(), e);
    end
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic test_random();
    logic [47:0] PX[NREQ][NP];
    logic [47:0] PY[NREQ][NP];
    int PL[NREQ][NP];
    int pk[NREQ];
    int bt[NREQ];
    int n;
    logic hold;
    rsp_t snap, e;
    do_reset();
    exp_q.delete();
    for (int r = 0; r < NREQ; r++) begin
      pk[r] = 0; bt[r] = 0;
      for (int p = 0; p < NP; p++) begin
        PL[r][p] = $urandom_range(1, 3);
        PX[r][p] = {rand_word(), rand_word(), rand_word()};
        PY[r][p] = {rand_word(), rand_word(), rand_word()};
      end
    end
    // Every requester always has a packet pending, so service is strict rotation.
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < NREQ; r++)
        ref_packet(r, PL[r][p], PX[r][p], PY[r][p]);
    hold = 1'b0;
    snap = '0;
    n = 0;
    while ((exp_q.size() > 0 || bus.rsp_valid) && n < 4000) begin
      @(negedge clk);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++) begin
        if (pk[r] < NP) begin
          bus.req_valid[r]      = (bt[r] == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
          bus.req_x[r*16 +: 16] = 16'(PX[r][pk[r]] >> (16 * bt[r]));
          bus.req_y[r*16 +: 16] = 16'(PY[r][pk[r]] >> (16 * bt[r]));
          bus.req_last[r]       = (bt[r] == PL[r][pk[r]] - 1);
        end else begin
          bus.req_valid[r] = 1'b0;
        end
      end
      #1;
      if (hold) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || cur_rsp() !== snap) begin
          errors++;
          $display("FAIL rand_stable got v=%b %h required v=1 %h", bus.rsp_valid, cur_rsp(), snap);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got %h required no response", cur_rsp());
        end else begin
          e = exp_q.pop_front();
          if (cur_rsp() !== e) begin
            errors++;
            $display("FAIL rand_rsp got %h required %h", cur_rsp(), e);
          end
        end
      end
      hold = bus.rsp_valid && !bus.rsp_ready;
      snap = cur_rsp();
      if ($countones(bus.req_ready) > 1) begin
        checks++; errors++;
        $display("FAIL rand_onehot got ready=%b required at most one bit", bus.req_ready);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (bus.req_valid[r] && bus.req_ready[r]) begin
          bt[r]++;
          if (bt[r] == PL[r][pk[r]]) begin
            bt[r] = 0;
            pk[r]++;
          end
        end
      end
      n++;
    end
    bus.req_valid = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_complete got %0d responses outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_chain32();
    test_zero_overflow();
    test_rr_order();
    test_backpressure();
    test_reset_midpacket();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
